keypad_entry_ctrl: RTL and testbench
====================================

// Module: keypad_entry_ctrl
// PURPOSE
//  Sequences the keypad scan/decode path into committed numeric operands. Consumes the
//  registered 4-bit key code from the scanner (4'hF = no key), qualifies press/release,
//  assembles up to NDIGITS decimal digits (BCD + binary), commits on a terminator key.
//  Sits between the keypad decoder and the arithmetic/display logic.
// PARAMETERS
//  STABLE_CYCLES  27_000  cycles a code must hold to accept a press or release (>=2)
//  NDIGITS        4       max digits per operand
//  BIN_W          14      width of binary accumulator (must hold 10**NDIGITS-1)
// PORTS
//  clk          in   1            system clock
//  n_reset      in   1            asynchronous active-low reset
//  key_code     in   4            decoded key: 0-9 digit, A/B/C op, D clear, E enter, F none
//  out_ready    in   1            consumer accepts committed operand
//  out_valid    out  1            committed operand available
//  out_bcd      out  4*NDIGITS    committed digits, BCD, least significant digit in [3:0]
//  out_bin      out  BIN_W        committed value, binary
//  out_ndigits  out  $clog2(NDIGITS+1)  number of digits entered
//  out_term     out  4            terminating key code (A, B, C or E)
//  out_ovf      out  1            >NDIGITS digits were typed; extras dropped
//  entry_bcd    out  4*NDIGITS    live entry buffer (for display)
//  key_strobe   out  1            1-cycle pulse when a press is accepted
// BEHAVIOUR
//  Reset (async, n_reset=0): state ARMED, cnt=0, all outputs/buffers 0.
//  States: ARMED, PRESS_CHK, HELD, REL_CHK, COMMIT.
//  ARMED: key_code!=F -> cand<=key_code, cnt<=1, PRESS_CHK.
//  PRESS_CHK: key_code!=cand -> ARMED, cnt<=0; cnt==STABLE_CYCLES-1 -> accept cand,
//    key_strobe=1 next cycle; else cnt++. Accept = end of STABLE_CYCLES-th consecutive
//    cycle of the same code; effect visible the following cycle.
//  Accept actions:
//    digit 0-9: if ndigits<NDIGITS: entry_bcd<={entry_bcd<<4,d}, bin<=bin*10+d,
//      ndigits++; else ovf<=1, buffers unchanged. -> HELD.
//    D: entry_bcd, bin, ndigits, ovf <= 0. -> HELD.
//    A/B/C/E: out_* <= entry buffers, out_term<=cand, out_valid<=1 -> COMMIT
//      (commit with 0 digits allowed: value 0, ndigits 0).
//  COMMIT: out_valid held, out_* stable; key presses ignored (not queued).
//    out_valid&&out_ready -> out_valid<=0, entry buffers cleared, -> HELD.
//  HELD: key_code==F -> cnt<=1, REL_CHK.
//  REL_CHK: key_code!=F -> HELD, cnt<=0; cnt==STABLE_CYCLES-1 -> ARMED; else cnt++.
//  One accepted action per physical press; a held key never repeats.
//  Glitch to another non-F code during PRESS_CHK restarts qualification from ARMED.
//  out_* change only on commit; entry_bcd updates on every digit/clear.
//  bin arithmetic unsigned, BIN_W bits, no wrap possible under parameter rule.
//  Reset asserted in any state (incl. COMMIT) drops out_valid immediately.
// TESTING  (bench: STABLE_CYCLES=4, NDIGITS=4)
//  Press 1,2,3 each 10 cyc with 10 cyc F between, then E -> out_valid=1, out_bcd=16'h0123,
//   out_bin=123, out_ndigits=3, out_term=E; held until out_ready=1, then 0.
//  Key 5 for 3 cyc then F -> no key_strobe, entry_bcd unchanged.
//  Key 7 held 100 cyc -> exactly one key_strobe, entry_bcd=16'h0007.
//  Digits 9,8,7,6,5 then B -> out_bcd=16'h9876, out_bin=9876, out_ovf=1, out_term=B.
//  Digits 4,2 then D then E -> out_valid=1, out_bin=0, out_ndigits=0.
//  Commit with out_ready=0, press 3, pull n_reset low mid-COMMIT -> press ignored,
//   out_valid=0 and state ARMED immediately on reset.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: debounces key press/release and assembles decimal operands
// (BCD and binary), committing them to the consumer on an operator or enter key.
module keypad_entry_ctrl #(
  parameter int unsigned STABLE_CYCLES = 27_000,
  parameter int unsigned NDIGITS       = 4,
  parameter int unsigned BIN_W         = 14
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic [3:0]                   key_code,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [4*NDIGITS-1:0]         out_bcd,
  output logic [BIN_W-1:0]             out_bin,
  output logic [$clog2(NDIGITS+1)-1:0] out_ndigits,
  output logic [3:0]                   out_term,
  output logic                         out_ovf,
  output logic [4*NDIGITS-1:0]         entry_bcd,
  output logic                         key_strobe
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES);
  localparam int unsigned NdW  = $clog2(NDIGITS + 1);
  localparam int unsigned BcdW = 4 * NDIGITS;

  localparam logic [CntW-1:0]  CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [NdW-1:0]   NdMax   = NdW'(NDIGITS);
  localparam logic [BIN_W-1:0] Ten     = BIN_W'(10);

  localparam logic [3:0] KeyClear = 4'hD;
  localparam logic [3:0] KeyNone  = 4'hF;

  typedef enum logic [2:0] {
    StArmed,
    StPressChk,
    StHeld,
    StRelChk,
    StCommit
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        cand_q, cand_d;
  logic [BcdW-1:0]   entry_q, entry_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [NdW-1:0]    nd_q, nd_d;
  logic              ovf_q, ovf_d;
  logic              strobe_q, strobe_d;
  logic              out_valid_q, out_valid_d;
  logic [BcdW-1:0]   out_bcd_q, out_bcd_d;
  logic [BIN_W-1:0]  out_bin_q, out_bin_d;
  logic [NdW-1:0]    out_nd_q, out_nd_d;
  logic [3:0]        out_term_q, out_term_d;
  logic              out_ovf_q, out_ovf_d;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= StArmed;
      cnt_q       <= '0;
      cand_q      <= '0;
      entry_q     <= '0;
      bin_q       <= '0;
      nd_q        <= '0;
      ovf_q       <= 1'b0;
      strobe_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_bin_q   <= '0;
      out_nd_q    <= '0;
      out_term_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      entry_q     <= entry_d;
      bin_q       <= bin_d;
      nd_q        <= nd_d;
      ovf_q       <= ovf_d;
      strobe_q    <= strobe_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_bin_q   <= out_bin_d;
      out_nd_q    <= out_nd_d;
      out_term_q  <= out_term_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    entry_d     = entry_q;
    bin_d       = bin_q;
    nd_d        = nd_q;
    ovf_d       = ovf_q;
    strobe_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_bin_d   = out_bin_q;
    out_nd_d    = out_nd_q;
    out_term_d  = out_term_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      StArmed: begin
        if (key_code != KeyNone) begin
          cand_d  = key_code;
          cnt_d   = CntOne;
          state_d = StPressChk;
        end
      end

      StPressChk: begin
        if (key_code != cand_q) begin
          // Any change of code, including a glitch to another key, restarts qualification.
          cnt_d   = '0;
          state_d = StArmed;
        end else if (cnt_q == CntLast) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          state_d  = StHeld;
          if (cand_q <= 4'd9) begin
            if (nd_q < NdMax) begin
              entry_d = {entry_q[BcdW-5:0], cand_q};
              bin_d   = bin_q * Ten + {{(BIN_W-4){1'b0}}, cand_q};
              nd_d    = nd_q + NdW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (cand_q == KeyClear) begin
            entry_d = '0;
            bin_d   = '0;
            nd_d    = '0;
            ovf_d   = 1'b0;
          end else if (cand_q != KeyNone) begin
            out_valid_d = 1'b1;
            out_bcd_d   = entry_q;
            out_bin_d   = bin_q;
            out_nd_d    = nd_q;
            out_term_d  = cand_q;
            out_ovf_d   = ovf_q;
            state_d     = StCommit;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StHeld: begin
        if (key_code == KeyNone) begin
          cnt_d   = CntOne;
          state_d = StRelChk;
        end
      end

      StRelChk: begin
        if (key_code != KeyNone) begin
          cnt_d   = '0;
          state_d = StHeld;
        end else if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StArmed;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StCommit: begin
        // Presses are not tracked here; the release check after HELD swallows any held key.
        if (out_ready) begin
          out_valid_d = 1'b0;
          entry_d     = '0;
          bin_d       = '0;
          nd_d        = '0;
          ovf_d       = 1'b0;
          state_d     = StHeld;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = StArmed;
      end
    endcase
  end

  assign out_valid   = out_valid_q;
  assign out_bcd     = out_bcd_q;
  assign out_bin     = out_bin_q;
  assign out_ndigits = out_nd_q;
  assign out_term    = out_term_q;
  assign out_ovf     = out_ovf_q;
  assign entry_bcd   = entry_q;
  assign key_strobe  = strobe_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus random press sequences checked
// against a digit-list model of operand entry.
module tb_keypad_entry_ctrl;

  localparam int unsigned S  = 4;
  localparam int unsigned ND = 4;
  localparam int unsigned BW = 14;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [3:0]  key_code = 4'hF;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_bcd;
  logic [BW-1:0] out_bin;
  logic [2:0]  out_ndigits;
  logic [3:0]  out_term;
  logic        out_ovf;
  logic [15:0] entry_bcd;
  logic        key_strobe;

  always #5 clk = ~clk;

  keypad_entry_ctrl #(
    .STABLE_CYCLES(S),
    .NDIGITS      (ND),
    .BIN_W        (BW)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .key_code   (key_code),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_bcd    (out_bcd),
    .out_bin    (out_bin),
    .out_ndigits(out_ndigits),
    .out_term   (out_term),
    .out_ovf    (out_ovf),
    .entry_bcd  (entry_bcd),
    .key_strobe (key_strobe)
  );

  int n_cmp = 0;
  int n_err = 0;
  int strobes;

  // Model: typed digits, most significant first, plus the last committed operand.
  int          digits[$];
  bit          m_ovf;
  bit          m_commit;
  logic [31:0] m_out_bcd;
  int          m_out_bin;
  int          m_out_nd;
  logic [3:0]  m_out_term;
  bit          m_out_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_bcd();
    logic [31:0] v = '0;
    int n = digits.size();
    for (int i = 0; i < n; i++) v = v + (32'(digits[i]) << (4 * (n - 1 - i)));
    return v;
  endfunction

  function automatic int model_bin();
    int v = 0;
    int n = digits.size();
    for (int i = 0; i < n; i++) begin
      int p = 1;
      for (int j = 0; j < n - 1 - i; j++) p = p * 10;
      v = v + digits[i] * p;
    end
    return v;
  endfunction

  task automatic model_reset();
    digits.delete();
    m_ovf = 0; m_commit = 0;
    m_out_bcd = '0; m_out_bin = 0; m_out_nd = 0; m_out_term = '0; m_out_ovf = 0;
  endtask

  task automatic model_apply(input logic [3:0] k);
    if (m_commit) return;
    if (k <= 4'd9) begin
      if (digits.size() < ND) digits.push_back(int'(k));
      else m_ovf = 1;
    end else if (k == 4'hD) begin
      digits.delete();
      m_ovf = 0;
    end else if (k != 4'hF) begin
      m_out_bcd  = model_bcd();
      m_out_bin  = model_bin();
      m_out_nd   = digits.size();
      m_out_term = k;
      m_out_ovf  = m_ovf;
      m_commit   = 1;
    end
  endtask

  task automatic step(input logic [3:0] k);
    @(negedge clk);
    if (key_strobe === 1'b1) strobes++;
    key_code = k;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".entry_bcd"}, 32'(entry_bcd), model_bcd());
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_commit));
    check({tag, ".out_bcd"}, 32'(out_bcd), m_out_bcd);
    check({tag, ".out_bin"}, 32'(out_bin), 32'(m_out_bin));
    check({tag, ".out_ndigits"}, 32'(out_ndigits), 32'(m_out_nd));
    check({tag, ".out_term"}, 32'(out_term), 32'(m_out_term));
    check({tag, ".out_ovf"}, 32'(out_ovf), 32'(m_out_ovf));
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap, input string tag);
    int exp_strobe;
    strobes = 0;
    exp_strobe = (!m_commit && hold >= int'(S)) ? 1 : 0;
    repeat (hold) step(k);
    repeat (gap) step(4'hF);
    if (exp_strobe != 0) model_apply(k);
    check({tag, ".strobes"}, 32'(strobes), 32'(exp_strobe));
    check_all(tag);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(out_valid), 32'(0));
    m_commit = 0;
    digits.delete();
    m_ovf = 0;
    repeat (10) step(4'hF);
    check_all(tag);
  endtask

  logic [3:0] terms[4];
  logic [3:0] k;
  int r;

  initial begin
    terms[0] = 4'hA; terms[1] = 4'hB; terms[2] = 4'hC; terms[3] = 4'hE;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset.key_strobe", 32'(key_strobe), 32'(0));
    check_all("reset");
    n_reset = 1'b1;
    repeat (3) step(4'hF);

    press(4'h1, 10, 10, "d1");
    press(4'h2, 10, 10, "d2");
    press(4'h3, 10, 10, "d3");
    press(4'hE, 10, 10, "enter123");
    check("enter123.bin_literal", 32'(out_bin), 32'd123);
    repeat (20) step(4'hF);
    check("enter123.valid_held", 32'(out_valid), 32'(1));
    handshake("hs123");

    press(4'h5, 3, 10, "short5");
    press(4'h7, 100, 10, "long7");
    check("long7.entry_literal", 32'(entry_bcd), 32'h0007);
    press(4'hD, 10, 10, "clr");

    press(4'h9, 10, 10, "o9");
    press(4'h8, 10, 10, "o8");
    press(4'h7, 10, 10, "o7");
    press(4'h6, 10, 10, "o6");
    press(4'h5, 10, 10, "o5");
    press(4'hB, 10, 10, "ovfB");
    check("ovfB.bcd_literal", 32'(out_bcd), 32'h9876);
    handshake("hsovf");

    press(4'h4, 10, 10, "c4");
    press(4'h2, 10, 10, "c2");
    press(4'hD, 10, 10, "cD");
    press(4'hE, 10, 10, "cE");
    handshake("hsclr");

    // Glitch from 5 to 6 mid-qualification: only 6 is accepted.
    strobes = 0;
    repeat (2) step(4'h5);
    repeat (10) step(4'h6);
    repeat (10) step(4'hF);
    model_apply(4'h6);
    check("glitch.strobes", 32'(strobes), 32'(1));
    check_all("glitch");

    for (int i = 0; i < 50; i++) begin
      r = $urandom_range(0, 99);
      if (m_commit && r < 40) begin
        handshake("rnd.hs");
      end else begin
        r = $urandom_range(0, 99);
        if (r < 60) press(4'($urandom_range(0, 9)), $urandom_range(S, 12), 10, "rnd.dig");
        else if (r < 70) press(4'hD, $urandom_range(S, 12), 10, "rnd.clr");
        else if (r < 85) press(terms[$urandom_range(0, 3)], $urandom_range(S, 12), 10, "rnd.term");
        else press(4'($urandom_range(0, 9)), $urandom_range(1, S - 1), 10, "rnd.short");
      end
    end
    if (m_commit) handshake("rnd.final");

    // Commit held without ready, extra press ignored, then async reset mid-COMMIT.
    press(4'h4, 10, 10, "r4");
    press(4'hE, 10, 10, "rE");
    press(4'h3, 10, 10, "r3ign");
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    model_reset();
    check("rst.out_valid", 32'(out_valid), 32'(0));
    check("rst.out_bcd", 32'(out_bcd), 32'(0));
    check("rst.entry_bcd", 32'(entry_bcd), 32'(0));
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) step(4'hF);
    press(4'h8, 10, 10, "post_rst8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
